// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/opcode entry sequencer.
// Opcode numbering must match the lab-board ALU.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_OP = 3'd1,
      LOAD_B  = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } seq_state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_MOD  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_LAST = OP_SHR;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   // Flags reported in place of the ALU's for a division or modulo by zero
   localparam logic [3:0] FLAGS_ZERO_ONLY = 4'b0001 << FLG_Z;

   function automatic logic is_unary(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR);
   endfunction

   function automatic logic is_divide(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Collects A, opcode and B from board switches on enter pulses, drives the ALU,
// waits a fixed settle time and registers the result and N/Z/C/V flags.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int Nbit        = 4,
   parameter int EXEC_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [Nbit-1:0] data_in,
   input  logic [3:0]      op_in,
   input  logic            enter,
   input  logic            chain,
   input  logic            clear,
   output logic [Nbit-1:0] alu_a,
   output logic [Nbit-1:0] alu_b,
   output logic [3:0]      alu_op_n,
   input  logic [Nbit-1:0] alu_result,
   input  logic [3:0]      alu_flags,
   output logic [Nbit-1:0] result_q,
   output logic [3:0]      flags_q,
   output logic            err_q,
   output logic            busy,
   output logic            done,
   output logic [2:0]      state_q
);

   localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

   seq_state_t       state;
   seq_state_t       state_next;
   logic [Nbit-1:0]  a_q;
   logic [Nbit-1:0]  b_q;
   logic [3:0]       op_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   logic load_a;
   logic load_op;
   logic load_b;
   logic chain_a;
   logic set_err;
   logic clr_err;
   logic cnt_load;
   logic capture;
   logic div_zero;

   assign div_zero = is_divide(op_q) && (b_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD_A;
      end else begin
         state <= state_next;
      end
   end

   // clear outranks enter everywhere; in EXEC it abandons the operation uncaptured
   always_comb begin
      state_next = state;
      load_a     = 1'b0;
      load_op    = 1'b0;
      load_b     = 1'b0;
      chain_a    = 1'b0;
      set_err    = 1'b0;
      clr_err    = 1'b0;
      cnt_load   = 1'b0;
      capture    = 1'b0;
      case (state)
         LOAD_A: begin
            if (clear) begin
               state_next = LOAD_A;
            end else if (enter) begin
               load_a     = 1'b1;
               clr_err    = 1'b1;
               state_next = LOAD_OP;
            end
         end
         LOAD_OP: begin
            if (clear) begin
               state_next = LOAD_A;
            end else if (enter) begin
               if (op_in <= OP_LAST) begin
                  load_op = 1'b1;
                  if (is_unary(op_in)) begin
                     cnt_load   = 1'b1;
                     state_next = EXEC;
                  end else begin
                     state_next = LOAD_B;
                  end
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         LOAD_B: begin
            if (clear) begin
               state_next = LOAD_A;
            end else if (enter) begin
               load_b     = 1'b1;
               cnt_load   = 1'b1;
               set_err    = is_divide(op_q) && (data_in == '0);
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (clear) begin
               state_next = LOAD_A;
            end else if (cnt_q == '0) begin
               capture    = 1'b1;
               state_next = SHOW;
            end
         end
         SHOW: begin
            if (clear) begin
               state_next = LOAD_A;
            end else if (enter) begin
               if (chain) begin
                  chain_a    = 1'b1;
                  state_next = LOAD_OP;
               end else begin
                  state_next = LOAD_A;
               end
            end
         end
         default: state_next = LOAD_A;
      endcase
   end

   // Settle counter: loaded on the way into EXEC, capture happens when it hits zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_load) begin
         cnt_q <= CNT_INIT;
      end else if ((state == EXEC) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         err_q   <= 1'b0;
      end else begin
         if (load_a) begin
            a_q <= data_in;
         end else if (chain_a) begin
            a_q <= result_q;
         end
         if (load_b) begin
            b_q <= data_in;
         end
         if (load_op) begin
            op_q <= op_in;
         end
         if (set_err) begin
            err_q <= 1'b1;
         end else if (clr_err) begin
            err_q <= 1'b0;
         end
      end
   end

   // The ALU output is meaningless for a zero divisor, so report a clean zero instead
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= capture;
         if (capture) begin
            if (div_zero) begin
               result_q <= '0;
               flags_q  <= FLAGS_ZERO_ONLY;
            end else begin
               result_q <= alu_result;
               flags_q  <= alu_flags;
            end
         end
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op_n = ~op_q;
   assign busy     = (state == EXEC);
   assign done     = done_q;
   assign state_q  = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 4-bit ALU attached;
// expected results are queued when operands are entered and checked on done.
module tb_alu_sequencer;

   localparam logic [2:0] ST_LOAD_A  = 3'd0;
   localparam logic [2:0] ST_LOAD_OP = 3'd1;
   localparam logic [2:0] ST_LOAD_B  = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] data_in;
   logic [3:0] op_in;
   logic       enter;
   logic       chain;
   logic       clear;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_op_n;
   logic [3:0] alu_result;
   logic [3:0] alu_flags;
   logic [3:0] result_q;
   logic [3:0] flags_q;
   logic       err_q;
   logic       busy;
   logic       done;
   logic [2:0] state_q;

   always #5 clk = ~clk;

   alu_sequencer #(.Nbit(4), .EXEC_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .op_in(op_in), .enter(enter),
      .chain(chain), .clear(clear), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op_n(alu_op_n), .alu_result(alu_result), .alu_flags(alu_flags),
      .result_q(result_q), .flags_q(flags_q), .err_q(err_q), .busy(busy),
      .done(done), .state_q(state_q)
   );

   // Board ALU stand-in: C is carry for add, borrow for sub, high-half nonzero for mul
   logic [3:0] m_op;
   logic [3:0] m_r;
   logic [4:0] m_sum;
   logic [7:0] m_prod;
   logic       m_c;
   logic       m_v;
   always_comb begin
      m_op   = ~alu_op_n;
      m_r    = 4'h0;
      m_c    = 1'b0;
      m_v    = 1'b0;
      m_sum  = 5'd0;
      m_prod = 8'd0;
      case (m_op)
         4'd0: begin
            m_sum = {1'b0, alu_a} + {1'b0, alu_b};
            m_r = m_sum[3:0];
            m_c = m_sum[4];
            m_v = (alu_a[3] == alu_b[3]) && (m_r[3] != alu_a[3]);
         end
         4'd1: begin
            m_r = alu_a - alu_b;
            m_c = alu_a < alu_b;
            m_v = (alu_a[3] != alu_b[3]) && (m_r[3] != alu_a[3]);
         end
         4'd2: begin
            m_prod = {4'd0, alu_a} * {4'd0, alu_b};
            m_r = m_prod[3:0];
            m_c = |m_prod[7:4];
            m_v = |m_prod[7:4];
         end
         4'd3: m_r = (alu_b != 0) ? alu_a / alu_b : 4'hF;
         4'd4: m_r = (alu_b != 0) ? alu_a % alu_b : 4'hA;
         4'd5: m_r = alu_a & alu_b;
         4'd6: m_r = alu_a | alu_b;
         4'd7: m_r = alu_a ^ alu_b;
         4'd8: begin m_r = alu_a << 1; m_c = alu_a[3]; end
         4'd9: begin m_r = alu_a >> 1; m_c = alu_a[0]; end
         default: m_r = 4'h0;
      endcase
      alu_result = m_r;
      alu_flags  = {m_r[3], (m_r == 4'h0), m_c, m_v};
   end

   typedef struct {
      logic       chain;
      logic [3:0] a;
      logic [3:0] op;
      logic [3:0] b;
      logic [3:0] res;
      logic [3:0] flg;
      logic       err;
   } vec_t;

   typedef struct {
      logic [3:0] res;
      logic [3:0] flg;
      logic       err;
   } exp_t;

   vec_t vecs[14];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   at_show  = 1'b0;
   int   busy_run = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at a falling edge; leaves enter high through the next rising edge
   task automatic stepEnter(input logic [3:0] d, input logic [3:0] o, input logic ch);
      data_in = d;
      op_in   = o;
      chain   = ch;
      enter   = 1'b1;
      @(negedge clk);
   endtask

   task automatic waitDone(input string name);
      int k;
      enter = 1'b0;
      k = 1;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput({name, " latency"}, done ? k : 0, 3);
      if (!done && sb.size() > 0) void'(sb.pop_front());
      at_show = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v, input string name);
      exp_t e;
      if (v.chain) begin
         stepEnter(4'h0, 4'h0, 1'b1);
         checkOutput({name, " chained a"}, alu_a, v.a);
         checkOutput({name, " state after chain"}, state_q, ST_LOAD_OP);
      end else begin
         if (at_show) stepEnter(4'h0, 4'h0, 1'b0);
         stepEnter(v.a, 4'h0, 1'b0);
         checkOutput({name, " err cleared on A"}, err_q, 0);
      end
      stepEnter(4'h0, v.op, 1'b0);
      checkOutput({name, " state after op"}, state_q,
                  (v.op == 4'd8 || v.op == 4'd9) ? ST_EXEC : ST_LOAD_B);
      if (!(v.op == 4'd8 || v.op == 4'd9)) stepEnter(v.b, 4'h0, 1'b0);
      e.res = v.res;
      e.flg = v.flg;
      e.err = v.err;
      sb.push_back(e);
      waitDone(name);
   endtask

   // Scoreboard side: pop on every done and check busy lasted the settle time
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("result_q", result_q, e.res);
               checkOutput("flags_q", flags_q, e.flg);
               checkOutput("err_q", err_q, e.err);
               checkOutput("busy cycles", busy_run, 2);
            end
            busy_run = 0;
         end else if (busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit seen_done;
      rst = 1'b1; data_in = 0; op_in = 0; enter = 0; chain = 0; clear = 0;
      //              ch    a      op     b      res    flg      err
      vecs[0]  = '{1'b0, 4'h3, 4'd0, 4'h4, 4'h7, 4'b0000, 1'b0};
      vecs[1]  = '{1'b0, 4'h5, 4'd8, 4'h0, 4'hA, 4'b1000, 1'b0};
      vecs[2]  = '{1'b0, 4'h6, 4'd3, 4'h0, 4'h0, 4'b0100, 1'b1};
      vecs[3]  = '{1'b0, 4'h3, 4'd0, 4'h4, 4'h7, 4'b0000, 1'b0};
      vecs[4]  = '{1'b1, 4'h7, 4'd2, 4'h2, 4'hE, 4'b1000, 1'b0};
      vecs[5]  = '{1'b0, 4'hC, 4'd1, 4'h5, 4'h7, 4'b0001, 1'b0};
      vecs[6]  = '{1'b0, 4'h9, 4'd4, 4'h4, 4'h1, 4'b0000, 1'b0};
      vecs[7]  = '{1'b0, 4'hA, 4'd7, 4'hA, 4'h0, 4'b0100, 1'b0};
      vecs[8]  = '{1'b0, 4'h9, 4'd9, 4'h0, 4'h4, 4'b0010, 1'b0};
      vecs[9]  = '{1'b0, 4'hF, 4'd0, 4'h1, 4'h0, 4'b0110, 1'b0};
      vecs[10] = '{1'b0, 4'hC, 4'd5, 4'hA, 4'h8, 4'b1000, 1'b0};
      vecs[11] = '{1'b0, 4'h3, 4'd6, 4'h4, 4'h7, 4'b0000, 1'b0};
      vecs[12] = '{1'b1, 4'h7, 4'd2, 4'h3, 4'h5, 4'b0011, 1'b0};
      vecs[13] = '{1'b0, 4'h9, 4'd4, 4'h0, 4'h0, 4'b0100, 1'b1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset state", state_q, ST_LOAD_A);
      checkOutput("reset alu_a", alu_a, 0);
      checkOutput("reset alu_b", alu_b, 0);
      checkOutput("reset alu_op_n", alu_op_n, 4'hF);
      checkOutput("reset result_q", result_q, 0);
      checkOutput("reset flags_q", flags_q, 0);
      checkOutput("reset err/busy/done", {err_q, busy, done}, 0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         if (i == 0) checkOutput("alu_op_n after add", alu_op_n, 4'hF);
         if (i == 1) checkOutput("unary keeps b", alu_b, 4'h4);
      end

      // Invalid opcode is rejected in place, then a valid one proceeds
      stepEnter(4'h0, 4'h0, 1'b0);
      stepEnter(4'h5, 4'h0, 1'b0);
      stepEnter(4'h0, 4'd12, 1'b0);
      checkOutput("bad op err", err_q, 1);
      checkOutput("bad op state", state_q, ST_LOAD_OP);
      stepEnter(4'h0, 4'd1, 1'b0);
      checkOutput("good op after bad", state_q, ST_LOAD_B);
      stepEnter(4'h2, 4'h0, 1'b0);
      sb.push_back('{4'h3, 4'b0000, 1'b1});
      waitDone("badop sub");

      // clear on the first EXEC cycle abandons the operation
      stepEnter(4'h0, 4'h0, 1'b0);
      stepEnter(4'h2, 4'h0, 1'b0);
      stepEnter(4'h0, 4'd0, 1'b0);
      stepEnter(4'h2, 4'h0, 1'b0);
      checkOutput("in exec before clear", state_q, ST_EXEC);
      enter = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checkOutput("clear state", state_q, ST_LOAD_A);
      checkOutput("clear keeps result", result_q, 4'h3);
      checkOutput("clear keeps flags", flags_q, 4'b0000);
      seen_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      checkOutput("no done after clear", seen_done, 0);
      at_show = 1'b0;

      // Reset while waiting for B
      stepEnter(4'h7, 4'h0, 1'b0);
      stepEnter(4'h0, 4'd0, 1'b0);
      checkOutput("in load_b before reset", state_q, ST_LOAD_B);
      enter = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst mid state", state_q, ST_LOAD_A);
      checkOutput("rst mid alu_a", alu_a, 0);
      checkOutput("rst mid alu_b", alu_b, 0);
      checkOutput("rst mid alu_op_n", alu_op_n, 4'hF);
      checkOutput("rst mid result_q", result_q, 0);
      checkOutput("rst mid flags_q", flags_q, 0);
      checkOutput("rst mid err/busy/done", {err_q, busy, done}, 0);

      checkOutput("scoreboard drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operand/opcode entry controller for the Nbit ALU on the lab board. It captures operand A, the opcode and (for binary ops) operand B from the switches on successive `enter` pulses. It then drives the ALU, waits a fixed settle time, and registers the result and the N/Z/C/V flags for the 7‑segment and LED outputs. It sits between the debounced board inputs and the ALU, and supports chaining the previous result back in as operand A.

## Interface
- `Nbit`, 4: operand/result width; must match the ALU.
- `EXEC_CYCLES`, 2: ALU settle cycles before capture; ≥1.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active‑high reset.
- `data_in` in Nbit: switch value used for operand A or B.
- `op_in` in 4: switch value used as the opcode.
- `enter` in 1: one‑cycle pulse, already debounced/synchronised.
- `chain` in 1: sampled with `enter` in SHOW only.
- `clear` in 1: abort to LOAD_A; sampled every cycle.
- `alu_a`, `alu_b` out Nbit: registered operands to the ALU.
- `alu_op_n` out 4: bitwise inverse of the registered opcode; the ALU opcode input is active‑low.
- `alu_result` in Nbit: ALU result.
- `alu_flags` in 4: ALU {N,Z,C,V}.
- `result_q` out Nbit: captured result.
- `flags_q` out 4: captured {N,Z,C,V}.
- `err_q` out 1: sticky error (bad opcode or divide/modulo by zero).
- `busy` out 1: high in EXEC.
- `done` out 1: one‑cycle pulse on the first SHOW cycle.
- `state_q` out 3: current state, for board LEDs.

## Operation
- Opcodes:
  - 0 add, 1 sub, 2 mul, 3 div, 4 mod.
  - 5 and, 6 or, 7 xor.
  - 8 shl, 9 shr. These are unary: B is not used.
  - 10–15 are invalid.
- State: LOAD_A
  - On `enter`: `a_q` ← `data_in`, `err_q` ← 0, go to LOAD_OP.
- State: LOAD_OP
  - On `enter` with `op_in` ≤ 9: `op_q` ← `op_in`. Go to EXEC if the op is 8 or 9, otherwise go to LOAD_B.
  - On `enter` with `op_in` ≥ 10: `err_q` ← 1, `op_q` unchanged, stay in LOAD_OP.
- State: LOAD_B
  - On `enter`: `b_q` ← `data_in`, go to EXEC.
  - If `op_q` ∈ {3,4} and `data_in` == 0: `err_q` ← 1 (still proceeds to EXEC).
- State: EXEC
  - Counter loads `EXEC_CYCLES`−1 on entry and decrements each cycle.
  - On the cycle the counter is 0: `result_q` ← `alu_result` and `flags_q` ← `alu_flags`. For div/mod by zero, force `result_q` ← 0 and `flags_q` ← 4'b0100 (Z only). Go to SHOW.
  - `enter` is ignored.
- State: SHOW
  - On `enter` with `chain`=1: `a_q` ← `result_q`, go to LOAD_OP.
  - On `enter` with `chain`=0: go to LOAD_A.
  - `result_q` and `flags_q` hold until the next capture.
- `clear`:
  - In any state except EXEC, `clear` has priority over `enter`: go to LOAD_A.
  - In EXEC, `clear` aborts without capture: go to LOAD_A, `result_q` and `flags_q` unchanged.
  - `a_q`, `b_q`, `op_q` and `err_q` are not cleared.
- Outputs:
  - `alu_a` = `a_q`, `alu_b` = `b_q`, `alu_op_n` = ~`op_q`.
  - `b_q` keeps its old value during unary ops.

## Timing
- Reset values:
  - State LOAD_A.
  - `a_q`, `b_q`, `result_q`, `flags_q` all 0; `op_q` = 0 (`alu_op_n` = 4'hF).
  - `err_q`, `busy`, `done` = 0.
- A register captures on the clock edge where `enter` is high; the new state is visible the next cycle.
- Latency, last `enter` to `done`: `EXEC_CYCLES`+1 cycles. With the default of 2, an `enter` at edge t gives EXEC at t+1 and t+2, and `done` at t+3.
- `busy` is high exactly for `EXEC_CYCLES` cycles.
- Consecutive `enter` pulses on back‑to‑back cycles are each honoured outside EXEC.
- Reset mid‑EXEC: no capture; all outputs return to reset values the next cycle.
- Width: all datapath registers are Nbit and no widening is done. Wrap‑around and overflow are the ALU's concern and are reported via V/C.

## Structure
- Package `alu_seq_pkg`:
  - state enum `seq_state_t` (LOAD_A, LOAD_OP, LOAD_B, EXEC, SHOW).
  - opcode localparams `OP_ADD`…`OP_SHR`, `OP_LAST` = 9.
  - flag index localparams `FLG_N`=3, `FLG_Z`=2, `FLG_C`=1, `FLG_V`=0.
- One module with one FSM plus an exec counter. No sub‑module. The ALU is instantiated by the top level, not inside this block.

## Test plan
- Reset, then enter A=3, op=0, B=4: EXEC for 2 cycles, `done` at +3, `result_q`=7, `flags_q`=0000, `alu_op_n`=4'hF.
- A=5, op=8 (shl): no LOAD_B visit, `result_q`=10, `b_q` unchanged.
- A=6, op=3, B=0: `err_q`=1, `result_q`=0, `flags_q`=0100. Next `enter` in LOAD_A clears `err_q`.
- op=12 in LOAD_OP: `err_q`=1, state stays LOAD_OP. Then op=1, B=2 with A=5: `result_q`=3.
- Chain: after 3+4=7, `enter` with `chain`=1 gives `a_q`=7; then op=2, B=2 gives `result_q`=14 and V per the ALU.
- `clear` on the first EXEC cycle: no `done`, `result_q` keeps its prior value, state LOAD_A. Reset asserted in LOAD_B: all outputs at reset values one cycle later.
